// File: rtl/nibble_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_pkg
//  Purpose  : Shared widths and assembly-state type for the nibble pair loader.
//  Revision : 1.0  initial release
// ============================================================================
package nibble_pkg;

    localparam int NIBBLE_W_DEF = 4;
    localparam int CNT_W_DEF    = 8;

    // S_IDLE: no first nibble held; S_FIRST: first nibble waiting for its partner
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FIRST = 1'b1
    } asm_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Purpose  : Up-counter that sticks at its all-ones value.
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    // Count up on inc, holding once the maximum is reached
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/nibble_pair_loader.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_pair_loader
//  Purpose  : Pairs consecutive nibbles from a valid/ready stream into a held
//             output slot, resynchronising on start-of-pair markers and
//             counting completed and dropped pairs.
//  Revision : 1.0  initial release
// ============================================================================
module nibble_pair_loader
    import nibble_pkg::*;
#(
    parameter int NIBBLE_W = NIBBLE_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NIBBLE_W-1:0] nib_data,
    input  logic                nib_sof,
    input  logic                nib_valid,
    output logic                nib_ready,
    output logic [NIBBLE_W-1:0] pair_1,
    output logic [NIBBLE_W-1:0] pair_2,
    output logic                pair_valid,
    input  logic                pair_ready,
    output logic [CNT_W-1:0]    pair_cnt,
    output logic [CNT_W-1:0]    drop_cnt
);

    asm_state_t          r_state;
    asm_state_t          w_state_nxt;
    logic [NIBBLE_W-1:0] r_first;
    logic [NIBBLE_W-1:0] r_pair_1;
    logic [NIBBLE_W-1:0] r_pair_2;
    logic                r_pair_valid;
    logic [CNT_W-1:0]    r_pair_cnt;

    logic                w_nib_acc;
    logic                w_take;
    logic                w_first_ld;
    logic                w_load;
    logic                w_drop;

    // A second nibble may only enter when the slot is free or being emptied;
    // first nibbles (idle state or sof) never touch the slot, so always enter
    assign nib_ready = (r_state == S_IDLE) | nib_sof | ~r_pair_valid | pair_ready;
    assign w_nib_acc = nib_valid & nib_ready;
    assign w_take    = r_pair_valid & pair_ready;

    // Next-state and action decode for an accepted nibble
    always_comb begin
        w_state_nxt = r_state;
        w_first_ld  = 1'b0;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        if (w_nib_acc) begin
            case (r_state)
                S_IDLE: begin
                    w_first_ld  = 1'b1;
                    w_state_nxt = S_FIRST;
                end
                S_FIRST: begin
                    if (nib_sof) begin
                        w_first_ld = 1'b1;
                        w_drop     = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Assembly state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Holding register for the first nibble of a pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_first <= '0;
        end else if (w_first_ld) begin
            r_first <= nib_data;
        end
    end

    // Output slot: a load wins over a take so back-to-back pairs keep valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pair_1     <= '0;
            r_pair_2     <= '0;
            r_pair_valid <= 1'b0;
        end else if (w_load) begin
            r_pair_1     <= r_first;
            r_pair_2     <= nib_data;
            r_pair_valid <= 1'b1;
        end else if (w_take) begin
            r_pair_valid <= 1'b0;
        end
    end

    // Completed-handshake counter, wrapping naturally at its width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pair_cnt <= '0;
        end else if (w_take) begin
            r_pair_cnt <= r_pair_cnt + CNT_W'(1);
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_drop_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_drop),
        .cnt   (drop_cnt)
    );

    assign pair_1     = r_pair_1;
    assign pair_2     = r_pair_2;
    assign pair_valid = r_pair_valid;
    assign pair_cnt   = r_pair_cnt;

endmodule
`default_nettype wire

// File: tb/tb_nibble_pair_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nibble_pair_loader
//  Purpose  : Directed and randomised self-checking bench for the nibble
//             pair loader against a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nibble_pair_loader;

    localparam int NW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NW-1:0] nib_data;
    logic          nib_sof;
    logic          nib_valid;
    logic          nib_ready;
    logic [NW-1:0] pair_1;
    logic [NW-1:0] pair_2;
    logic          pair_valid;
    logic          pair_ready;
    logic [CW-1:0] pair_cnt;
    logic [CW-1:0] drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: an optional pending first nibble, one held pair, counts
    bit m_have;
    int m_first;
    int m_p1;
    int m_p2;
    bit m_pv;
    int m_pcnt;
    int m_dcnt;

    always #5 clk = ~clk;

    nibble_pair_loader #(
        .NIBBLE_W (NW),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .nib_data   (nib_data),
        .nib_sof    (nib_sof),
        .nib_valid  (nib_valid),
        .nib_ready  (nib_ready),
        .pair_1     (pair_1),
        .pair_2     (pair_2),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .pair_cnt   (pair_cnt),
        .drop_cnt   (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // A nibble is refused only when it would complete a pair into an occupied,
    // not-being-taken slot
    function automatic bit m_ready();
        return !m_have || nib_sof || !m_pv || pair_ready;
    endfunction

    task automatic model_reset();
        m_have  = 1'b0;
        m_first = 0;
        m_p1    = 0;
        m_p2    = 0;
        m_pv    = 1'b0;
        m_pcnt  = 0;
        m_dcnt  = 0;
    endtask

    task automatic model_edge();
        bit take;
        bit acc;
        bit loaded;
        take   = m_pv && pair_ready;
        acc    = nib_valid && m_ready();
        loaded = 1'b0;
        if (acc) begin
            if (!m_have) begin
                m_have  = 1'b1;
                m_first = int'(nib_data);
            end else if (nib_sof) begin
                m_first = int'(nib_data);
                m_dcnt  = (m_dcnt >= 255) ? 255 : m_dcnt + 1;
            end else begin
                m_p1   = m_first;
                m_p2   = int'(nib_data);
                m_have = 1'b0;
                loaded = 1'b1;
            end
        end
        if (take) m_pcnt = (m_pcnt + 1) % 256;
        if (loaded) m_pv = 1'b1;
        else if (take) m_pv = 1'b0;
    endtask

    task automatic check_outputs();
        check("pair_1", pair_1, m_p1);
        check("pair_2", pair_2, m_p2);
        check("pair_valid", pair_valid, m_pv);
        check("pair_cnt", pair_cnt, m_pcnt);
        check("drop_cnt", drop_cnt, m_dcnt);
    endtask

    // Called one time unit after an edge with inputs already driven
    task automatic cycle(input int exp_rdy = -1);
        #1;
        check("nib_ready", nib_ready, m_ready());
        if (exp_rdy >= 0) check("nib_ready_directed", nib_ready, exp_rdy);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit v, input int d, input bit sof, input bit pr);
        nib_valid  = v;
        nib_data   = NW'(d);
        nib_sof    = sof;
        pair_ready = pr;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        drive(0, 0, 0, 0);
        rst_n = 1'b1;
        model_reset();
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // reset values while reset is held
        check("rst_pair_1", pair_1, 0);
        check("rst_pair_2", pair_2, 0);
        check("rst_pair_valid", pair_valid, 0);
        check("rst_pair_cnt", pair_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_nib_ready", nib_ready, 1);
        rst_n = 1'b1;

        // single pair A,5 then take
        drive(1, 'hA, 1, 1); cycle(1);
        drive(1, 'h5, 0, 1); cycle(1);
        check("t1_pair_1", pair_1, 'hA);
        check("t1_pair_2", pair_2, 'h5);
        check("t1_valid", pair_valid, 1);
        drive(0, 0, 0, 1); cycle();
        check("t1_pair_cnt", pair_cnt, 1);
        check("t1_valid_clear", pair_valid, 0);

        // continuous stream 1..8
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive(1, i, (i % 2) == 1, 1);
            cycle(1);
            if ((i % 2) == 0) begin
                check("t2_pair_1", pair_1, i - 1);
                check("t2_pair_2", pair_2, i);
            end
        end
        drive(0, 0, 0, 1); cycle();
        check("t2_pair_cnt", pair_cnt, 4);

        // backpressure with a pending pair
        do_reset();
        drive(1, 'h3, 1, 0); cycle(1);
        drive(1, 'hC, 0, 0); cycle(1);
        drive(1, 'h7, 1, 0); cycle(1);
        for (int k = 0; k < 3; k++) begin
            drive(1, 'h9, 0, 0); cycle(0);
            check("t3_hold_p1", pair_1, 'h3);
            check("t3_hold_p2", pair_2, 'hC);
            check("t3_hold_valid", pair_valid, 1);
        end
        drive(1, 'h9, 0, 1); cycle(1);
        check("t3_next_p1", pair_1, 'h7);
        check("t3_next_p2", pair_2, 'h9);
        check("t3_next_valid", pair_valid, 1);
        check("t3_pair_cnt", pair_cnt, 1);

        // resync drop
        do_reset();
        drive(1, 'h2, 1, 1); cycle(1);
        drive(1, 'h4, 1, 1); cycle(1);
        drive(1, 'h6, 0, 1); cycle(1);
        check("t4_pair_1", pair_1, 'h4);
        check("t4_pair_2", pair_2, 'h6);
        check("t4_drop_cnt", drop_cnt, 1);

        // pair counter wrap after 256 takes
        do_reset();
        for (int i = 0; i < 512; i++) begin
            drive(1, i % 16, (i % 2) == 0, 1);
            cycle(1);
        end
        check("t5_pair_cnt_255", pair_cnt, 255);
        drive(0, 0, 0, 1); cycle();
        check("t5_pair_cnt_wrap", pair_cnt, 0);

        // drop counter saturation after 300 drops
        do_reset();
        for (int i = 0; i < 301; i++) begin
            drive(1, i % 16, 1, 0);
            cycle(1);
        end
        check("t5_drop_sat", drop_cnt, 255);

        // asynchronous reset with a held first nibble and a pending pair
        do_reset();
        drive(1, 'h1, 1, 0); cycle();
        drive(1, 'h2, 0, 0); cycle();
        drive(1, 'h3, 1, 0); cycle();
        drive(0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", pair_valid, 0);
        check("t6_async_p1", pair_1, 0);
        check("t6_async_p2", pair_2, 0);
        check("t6_async_ready", nib_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        drive(1, 'hF, 1, 0); cycle(1);
        drive(1, 'h0, 0, 0); cycle(1);
        check("t6_fresh_p1", pair_1, 'hF);
        check("t6_fresh_p2", pair_2, 'h0);
        check("t6_fresh_valid", pair_valid, 1);
        check("t6_fresh_drop", drop_cnt, 0);

        // randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, $urandom % 16, ($urandom % 3) == 0, ($urandom % 2) == 1);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
